// File: rtl/plic_ctrl.sv
// Bus-facing configuration and claim/complete sequencer for the plic block.
// Holds priority/enable/threshold registers and gates cpu_irq through an IDLE/NOTIFY/CLAIM/SERVICE FSM.

module plic_ctrl_prio #(
  parameter int PRIO_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wen,
  input  logic [PRIO_W-1:0] wdata,
  output logic [PRIO_W-1:0] prio_q
);
  logic [PRIO_W-1:0] prio_d;

  always_comb begin
    prio_d = prio_q;
    if (wen) prio_d = wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) prio_q <= '0;
    else     prio_q <= prio_d;
  end
endmodule

module plic_ctrl #(
  parameter int PORTS  = 4,
  parameter int ID_W   = 2,
  parameter int PRIO_W = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              bus_addr,
  input  logic                    bus_wen,
  input  logic                    bus_ren,
  input  logic [31:0]             bus_wdata,
  output logic [31:0]             bus_rdata,
  input  logic                    plic_pending,
  input  logic [ID_W-1:0]         plic_id,
  output logic [PORTS-1:0]        int_enable,
  output logic [PORTS*PRIO_W-1:0] int_priority,
  output logic [PORTS-1:0]        int_claim,
  output logic                    cpu_irq
);
  localparam logic [3:0] ADDR_ENABLE = 4'd8;
  localparam logic [3:0] ADDR_THRESH = 4'd9;
  localparam logic [3:0] ADDR_CLAIM  = 4'd10;
  localparam logic [3:0] ADDR_STATUS = 4'd11;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_NOTIFY  = 2'd1;
  localparam logic [1:0] S_CLAIM   = 2'd2;
  localparam logic [1:0] S_SERVICE = 2'd3;

  logic [PORTS-1:0][PRIO_W-1:0] prio_q;
  logic [PORTS-1:0]             prio_wen;
  logic [PORTS-1:0]             enable_q, enable_d;
  logic [PRIO_W-1:0]            thresh_q, thresh_d;
  logic [1:0]                   state_q, state_d;
  logic [ID_W-1:0]              active_id_q, active_id_d;
  logic [31:0]                  rdata_q, rdata_d;

  logic [PRIO_W-1:0] sel_prio;
  logic              eligible;
  logic              claim_rd;
  logic              complete_wr;
  logic              complete_ok;
  logic              in_service;
  logic [31:0]       claim_val;
  logic [31:0]       status_val;
  logic [31:0]       rd_val;

  for (genvar i = 0; i < PORTS; i++) begin : g_src
    assign prio_wen[i] = bus_wen && (bus_addr == 4'(i));
    plic_ctrl_prio #(.PRIO_W(PRIO_W)) u_prio (
      .clk    (clk),
      .rst    (rst),
      .wen    (prio_wen[i]),
      .wdata  (bus_wdata[PRIO_W-1:0]),
      .prio_q (prio_q[i])
    );
  end

  // Priority of whatever source the plic currently reports; out-of-range ids count as priority 0.
  always_comb begin
    sel_prio = '0;
    for (int i = 0; i < PORTS; i++)
      if (plic_id == ID_W'(i)) sel_prio = prio_q[i];
  end

  assign eligible    = plic_pending && (sel_prio > thresh_q);
  assign claim_rd    = bus_ren && !bus_wen && (bus_addr == ADDR_CLAIM);
  assign complete_wr = bus_wen && (bus_addr == ADDR_CLAIM);
  assign complete_ok = bus_wdata == ({{(32-ID_W){1'b0}}, active_id_q} + 32'd1);
  assign in_service  = (state_q == S_CLAIM) || (state_q == S_SERVICE);

  always_comb begin
    state_d     = state_q;
    active_id_d = active_id_q;
    claim_val   = '0;
    case (state_q)
      S_IDLE: if (eligible) state_d = S_NOTIFY;
      S_NOTIFY: begin
        if (claim_rd && eligible) begin
          active_id_d = plic_id;
          claim_val   = {{(32-ID_W){1'b0}}, plic_id} + 32'd1;
          state_d     = S_CLAIM;
        end else if (!eligible) begin
          state_d = S_IDLE;
        end
      end
      S_CLAIM:   state_d = S_SERVICE;
      S_SERVICE: if (complete_wr && complete_ok) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    status_val             = '0;
    status_val[0]          = cpu_irq;
    status_val[1]          = in_service;
    status_val[2 +: ID_W]  = in_service ? active_id_q : '0;
  end

  always_comb begin
    rd_val = '0;
    case (bus_addr)
      ADDR_ENABLE: rd_val = 32'(enable_q);
      ADDR_THRESH: rd_val = 32'(thresh_q);
      ADDR_CLAIM:  rd_val = claim_val;
      ADDR_STATUS: rd_val = status_val;
      default: begin
        for (int i = 0; i < PORTS; i++)
          if (bus_addr == 4'(i)) rd_val = 32'(prio_q[i]);
      end
    endcase
  end

  // A simultaneous write wins: read data is forced to 0 and claim_rd already excludes the claim.
  always_comb begin
    rdata_d  = rdata_q;
    enable_d = enable_q;
    thresh_d = thresh_q;
    if (bus_ren) rdata_d = bus_wen ? '0 : rd_val;
    if (bus_wen && bus_addr == ADDR_ENABLE) enable_d = bus_wdata[PORTS-1:0];
    if (bus_wen && bus_addr == ADDR_THRESH) thresh_d = bus_wdata[PRIO_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q    <= '0;
      thresh_q    <= '0;
      state_q     <= S_IDLE;
      active_id_q <= '0;
      rdata_q     <= '0;
    end else begin
      enable_q    <= enable_d;
      thresh_q    <= thresh_d;
      state_q     <= state_d;
      active_id_q <= active_id_d;
      rdata_q     <= rdata_d;
    end
  end

  always_comb begin
    int_claim = '0;
    for (int i = 0; i < PORTS; i++)
      int_claim[i] = (state_q == S_CLAIM) && (active_id_q == ID_W'(i));
  end

  assign cpu_irq      = (state_q == S_NOTIFY);
  assign bus_rdata    = rdata_q;
  assign int_enable   = enable_q;
  assign int_priority = prio_q;
endmodule

// File: tb/tb_plic_ctrl.sv
// Bench for plic_ctrl: directed claim/complete scenarios followed by random bus traffic,
// all checked each cycle against a rule-level model of the controller.

module tb_plic_ctrl;
  localparam int PORTS  = 4;
  localparam int ID_W   = 2;
  localparam int PRIO_W = 3;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [3:0]              bus_addr;
  logic                    bus_wen;
  logic                    bus_ren;
  logic [31:0]             bus_wdata;
  logic [31:0]             bus_rdata;
  logic                    plic_pending;
  logic [ID_W-1:0]         plic_id;
  logic [PORTS-1:0]        int_enable;
  logic [PORTS*PRIO_W-1:0] int_priority;
  logic [PORTS-1:0]        int_claim;
  logic                    cpu_irq;

  plic_ctrl #(.PORTS(PORTS), .ID_W(ID_W), .PRIO_W(PRIO_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus_addr     (bus_addr),
    .bus_wen      (bus_wen),
    .bus_ren      (bus_ren),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata),
    .plic_pending (plic_pending),
    .plic_id      (plic_id),
    .int_enable   (int_enable),
    .int_priority (int_priority),
    .int_claim    (int_claim),
    .cpu_irq      (cpu_irq)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: configuration, whether a claim is outstanding, and what the CPU currently sees.
  logic [PRIO_W-1:0] m_prio [PORTS];
  logic [PORTS-1:0]  m_en;
  logic [PRIO_W-1:0] m_thr;
  bit                m_busy;
  bit                m_just;
  bit                m_irq;
  int                m_act;
  logic [31:0]       m_rdata;
  logic [PORTS-1:0]  m_claim;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < PORTS; i++) m_prio[i] = '0;
    m_en = '0; m_thr = '0;
    m_busy = 0; m_just = 0; m_irq = 0; m_act = 0;
    m_rdata = '0; m_claim = '0;
  endtask

  // One bus cycle: drive inputs, advance the model by the rules, clock, compare every output.
  task automatic step(input bit r, input bit we, input bit re, input logic [3:0] a, input logic [31:0] wd);
    bit          elig, clm, cmp, nirq;
    logic [31:0] nr;
    logic [PORTS*PRIO_W-1:0] exp_pri;
    rst = r; bus_wen = we; bus_ren = re; bus_addr = a; bus_wdata = wd;
    if (r) begin
      model_reset();
    end else begin
      elig = plic_pending && (m_prio[plic_id] > m_thr);
      clm  = re && !we && a == 4'd10 && m_irq && elig;
      if (re) begin
        nr = 0;
        if (!we) begin
          if (a < 4'd4)        nr = 32'(m_prio[a[1:0]]);
          else if (a == 4'd8)  nr = 32'(m_en);
          else if (a == 4'd9)  nr = 32'(m_thr);
          else if (a == 4'd10) nr = clm ? 32'(plic_id) + 1 : 0;
          else if (a == 4'd11) nr = (m_busy ? 32'(m_act) << 2 : 0) | (32'(m_busy) << 1) | 32'(m_irq);
        end
        m_rdata = nr;
      end
      cmp  = we && a == 4'd10 && m_busy && !m_just && wd == 32'(m_act + 1);
      nirq = !m_busy && elig && !clm;
      m_just = clm;
      if (clm) begin m_busy = 1; m_act = int'(plic_id); end
      else if (cmp) m_busy = 0;
      m_irq   = nirq;
      m_claim = clm ? (PORTS'(1) << plic_id) : '0;
      if (we) begin
        if (a < 4'd4)       m_prio[a[1:0]] = wd[PRIO_W-1:0];
        else if (a == 4'd8) m_en  = wd[PORTS-1:0];
        else if (a == 4'd9) m_thr = wd[PRIO_W-1:0];
      end
    end
    @(posedge clk); #1;
    rst = 0; bus_wen = 0; bus_ren = 0;
    for (int i = 0; i < PORTS; i++) exp_pri[i*PRIO_W +: PRIO_W] = m_prio[i];
    check("cpu_irq",      32'(cpu_irq),      32'(m_irq));
    check("int_claim",    32'(int_claim),    32'(m_claim));
    check("bus_rdata",    bus_rdata,         m_rdata);
    check("int_enable",   32'(int_enable),   32'(m_en));
    check("int_priority", 32'(int_priority), 32'(exp_pri));
  endtask

  task automatic idle();    step(0, 0, 0, 4'd0, 0); endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d); step(0, 1, 0, a, d); endtask
  task automatic rd(input logic [3:0] a); step(0, 0, 1, a, 0); endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          we, re;
    logic [3:0]  a;
    logic [31:0] d;
    int          op;

    rst = 1; bus_wen = 0; bus_ren = 0; bus_addr = 0; bus_wdata = 0;
    plic_pending = 0; plic_id = 0;
    model_reset();
    step(1, 0, 0, 4'd0, 0);
    step(1, 0, 0, 4'd0, 0);

    // Reset state: every register reads 0.
    for (int i = 0; i < 16; i++) begin
      rd(4'(i));
      check("reset_read", bus_rdata, 32'd0);
    end

    // Basic claim of source 2.
    wr(4'd0, 3); wr(4'd1, 2); wr(4'd2, 4); wr(4'd3, 1);
    wr(4'd8, 32'hF); wr(4'd9, 0);
    check("enable_out", 32'(int_enable), 32'hF);
    check("prio_out",   32'(int_priority), {20'd0, 3'd1, 3'd4, 3'd2, 3'd3});
    plic_pending = 1; plic_id = 2;
    idle();
    check("irq_rise", 32'(cpu_irq), 32'd1);
    rd(4'd10);
    check("claim_id3",   bus_rdata, 32'd3);
    check("claim_pulse", 32'(int_claim), 32'b0100);
    idle();
    check("pulse_one_cycle", 32'(int_claim), 32'd0);
    check("irq_in_service",  32'(cpu_irq), 32'd0);
    rd(4'd11);
    check("status_service", bus_rdata, 32'b1010);

    // No nesting in service, wrong complete ignored, right complete re-arms.
    plic_id = 0;
    rd(4'd10);
    check("nested_claim_zero", bus_rdata, 32'd0);
    check("nested_no_pulse",   32'(int_claim), 32'd0);
    wr(4'd10, 2); idle();
    check("bad_complete_ignored", 32'(cpu_irq), 32'd0);
    wr(4'd10, 3); idle();
    check("irq_after_complete", 32'(cpu_irq), 32'd1);
    rd(4'd10);
    check("claim_id1",    bus_rdata, 32'd1);
    check("claim_pulse0", 32'(int_claim), 32'b0001);
    idle(); wr(4'd10, 1); idle();

    // Threshold gating.
    plic_pending = 1; plic_id = 1;
    wr(4'd9, 2); idle(); idle();
    check("thr_blocks_equal", 32'(cpu_irq), 32'd0);
    plic_id = 0; idle();
    check("thr_passes", 32'(cpu_irq), 32'd1);
    wr(4'd9, 3); idle();
    check("thr_raise_drop", 32'(cpu_irq), 32'd0);
    rd(4'd10);
    check("claim_after_drop", bus_rdata, 32'd0);

    // Simultaneous read and write while notifying.
    wr(4'd9, 0); idle();
    check("renotify", 32'(cpu_irq), 32'd1);
    step(0, 1, 1, 4'd10, 1);
    check("rw_claim_rdata", bus_rdata, 32'd0);
    check("rw_claim_nopulse", 32'(int_claim), 32'd0);
    step(0, 1, 1, 4'd9, 5);
    check("rw_thr_rdata", bus_rdata, 32'd0);
    idle();
    rd(4'd9);
    check("rw_thr_written", bus_rdata, 32'd5);
    check("rw_thr_irq_off", 32'(cpu_irq), 32'd0);

    // Reset mid-service.
    wr(4'd9, 0); idle();
    rd(4'd10); idle();
    rd(4'd11);
    check("pre_reset_status", bus_rdata, 32'b0010);
    step(1, 0, 0, 4'd0, 0);
    check("reset_rdata", bus_rdata, 32'd0);
    check("reset_claim", 32'(int_claim), 32'd0);
    rd(4'd11);
    check("reset_status", bus_rdata, 32'd0);
    for (int i = 0; i < 4; i++) idle();
    check("reset_prio0_no_irq", 32'(cpu_irq), 32'd0);

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      plic_pending = ($urandom_range(0, 9) < 8);
      plic_id      = ID_W'($urandom_range(0, PORTS - 1));
      op = $urandom_range(0, 99);
      we = 0; re = 0; a = 4'($urandom_range(0, 15)); d = $urandom;
      if (op < 25) begin
      end else if (op < 45) begin
        we = 1; d = $urandom_range(0, 7);
      end else if (op < 60) begin
        re = 1;
      end else if (op < 75) begin
        re = 1; a = 4'd10;
      end else if (op < 88) begin
        we = 1; a = 4'd10;
        d = ($urandom_range(0, 9) < 7) ? 32'(m_act + 1) : 32'($urandom_range(0, 5));
      end else if (op < 93) begin
        we = 1; re = 1; d = $urandom_range(0, 7);
      end else if (op < 99) begin
        re = 1; a = 4'd11;
      end else begin
        step(1, 0, 0, 4'd0, 0);
        continue;
      end
      step(0, we, re, a, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/plic_ctrl.md
Name: plic_ctrl

Overview:
Memory-mapped controller between the CPU bus and the plic block. It holds the PLIC configuration registers (per-source priority, enable mask, priority threshold) and drives them onto the plic inputs. It sequences the claim/complete protocol: it raises cpu_irq for an eligible pending source, returns the id on a CLAIM read, pulses the matching int_claim bit, and blocks further notification until the CPU writes COMPLETE.

Parameters:
PORTS, 4, number of interrupt sources (1..8)
ID_W, 2, width of plic_id (clog2(PORTS), min 1)
PRIO_W, 3, width of each priority field and the threshold

Ports:
clk  in  1  system clock, all state on posedge
rst  in  1  synchronous active-high reset
bus_addr  in  4  word address
bus_wen  in  1  write strobe, single cycle
bus_ren  in  1  read strobe, single cycle
bus_wdata  in  32  write data
bus_rdata  out  32  registered read data
plic_pending  in  1  plic out_int_pending
plic_id  in  ID_W  plic out_int_id (highest-priority pending source)
int_enable  out  PORTS  enable mask to plic
int_priority  out  PORTS*PRIO_W  priorities to plic; source i at [i*PRIO_W +: PRIO_W]
int_claim  out  PORTS  one-hot claim pulse to plic
cpu_irq  out  1  external interrupt request to CPU

Behaviour:
- Register map (word address): 0..PORTS-1 PRIO[i] RW, low PRIO_W bits; 8 ENABLE RW, low PORTS bits; 9 THRESHOLD RW, low PRIO_W bits; 10 CLAIM (read = claim, write = complete); 11 STATUS RO: bit0 cpu_irq, bit1 in-service, bits[2+:ID_W] active id. Unmapped reads return 0. Unmapped writes are ignored. Unused upper bits read as 0.
- Reset (any cycle, including mid-service): all PRIO = 0, ENABLE = 0, THRESHOLD = 0, state IDLE, bus_rdata = 0, int_claim = 0, cpu_irq = 0. No claim pulse is issued by reset.
- eligible (combinational) = plic_pending && PRIO[plic_id] > THRESHOLD. A priority of 0 is never eligible.
- Reads: bus_rdata is updated on the clock edge that samples bus_ren, so data is valid the cycle after the strobe. bus_rdata holds its value until the next read.
- If bus_wen and bus_ren are both asserted, the write executes, bus_rdata = 0, and the claim side effect is suppressed.
- Config writes take effect on int_enable/int_priority the cycle after bus_wen.
- FSM states: IDLE, NOTIFY, CLAIM, SERVICE. cpu_irq is registered and is 1 only in NOTIFY.
  - IDLE -> NOTIFY when eligible. cpu_irq rises 1 cycle after eligible rises.
  - NOTIFY -> IDLE when eligibility drops with no claim (threshold raised, source masked, pending cleared).
  - NOTIFY + CLAIM read while eligible: latch active_id = plic_id, set bus_rdata = active_id + 1, go to CLAIM.
  - NOTIFY + CLAIM read while not eligible (same-cycle drop): bus_rdata = 0, go to IDLE.
  - CLAIM: int_claim = one-hot(active_id) for exactly this one cycle, aligned with bus_rdata becoming valid. Always go to SERVICE next.
  - SERVICE: cpu_irq = 0, no nesting. A CLAIM read returns 0 with no pulse. A COMPLETE write with wdata == active_id + 1 goes to IDLE. Any other value is ignored and the block stays in SERVICE.
  - A COMPLETE write in IDLE, NOTIFY or CLAIM is ignored.
  - A CLAIM read in IDLE returns 0.
- Id encoding on the bus is id + 1; 0 means "no interrupt".
- int_claim is 0 in every state except CLAIM.

Test Plan:
- Reset, then read all registers -> every read returns 0; cpu_irq = 0; int_claim = 0; int_priority = 0.
- Write PRIO = {3,2,4,1}, ENABLE = 4'b1111, THRESHOLD = 0; drive plic_pending = 1, plic_id = 2 -> cpu_irq = 1 one cycle later; CLAIM read returns 3; int_claim = 4'b0100 for exactly 1 cycle; cpu_irq = 0; STATUS = 0b1010.
- In SERVICE with plic_id now 0: CLAIM read -> returns 0, no int_claim pulse. Write COMPLETE = 2 -> ignored. Write COMPLETE = 3 -> IDLE; cpu_irq = 1 the following cycle; next CLAIM returns 1; int_claim = 4'b0001.
- THRESHOLD = 2 with plic_id = 1 (prio 2) pending -> cpu_irq stays 0. Change plic_id to 0 (prio 3) -> cpu_irq = 1. Write THRESHOLD = 3 -> cpu_irq drops to 0 within 2 cycles; CLAIM read returns 0.
- CLAIM read and bus_wen to THRESHOLD in the same cycle during NOTIFY -> THRESHOLD updated, bus_rdata = 0, no pulse, state remains governed by eligibility.
- Assert rst during SERVICE -> next cycle all registers 0, STATUS = 0, no int_claim pulse; after release with plic_pending = 1, cpu_irq stays 0 (all priorities 0).
